vga_grid_capture: RTL and testbench



---
 rtl/vga_grid_capture.sv | 160 ++++++++++++++++
 tb/tb_vga_grid_capture.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_grid_capture.sv
// Recovers pixel coordinates from a registered VGA stream and captures the green plane at
// tile centres into a double-buffered bitmap. Optional border checker: VGA_BORDER_CHECK_EN.
module vga_grid_capture #(
    parameter int unsigned H_TOTAL      = 768,
    parameter int unsigned H_SYNC_START = 720,
    parameter int unsigned V_TOTAL      = 512,
    parameter int unsigned V_SYNC_LINE  = 500,
    parameter int unsigned TILE_SHIFT   = 5,
    parameter int unsigned COLS         = 16,
    parameter int unsigned ROWS         = 14
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            vga_h_sync,
    input  logic            vga_v_sync,
    input  logic            vga_R,
    input  logic            vga_G,
    input  logic [3:0]      rd_row,
    output logic [COLS-1:0] rd_data,
    output logic            locked,
    output logic            frame_valid,
    output logic            sync_err,
    output logic            border_err
);
    localparam int unsigned   CW           = 10;
    localparam int unsigned   COL_W        = $clog2(COLS);
    localparam int unsigned   ROW_W        = $clog2(ROWS);
    localparam logic [CW-1:0] H_LAST       = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST       = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_SYNC_X     = CW'(H_SYNC_START);
    localparam logic [CW-1:0] V_SYNC_Y     = CW'(V_SYNC_LINE);
    localparam logic [CW-1:0] CENTRE       = CW'(1 << (TILE_SHIFT - 1));
    localparam logic [CW-1:0] TILE_MASK    = CW'((1 << TILE_SHIFT) - 1);
    localparam logic [CW-1:0] COLS_C       = CW'(COLS);
    localparam logic [CW-1:0] ROWS_C       = CW'(ROWS);
    localparam logic [CW-1:0] ACTIVE_END_Y = CW'(ROWS << TILE_SHIFT);

    typedef enum logic [1:0] {SEARCH, HSYNC, LOCKED} state_t;
    state_t state, state_next;

    logic             h_s, v_s, r_s, g_s, h_p, v_p;
    logic             h_edge, v_edge;
    logic [CW-1:0]    x, y, x_eff, y_eff, x_next, y_next;
    logic [CW-1:0]    col, row;
    logic [COL_W-1:0] col_idx;
    logic [ROW_W-1:0] row_idx;
    logic             misalign, sample, swap, frame_done;
    logic [COLS-1:0]  back  [ROWS];
    logic [COLS-1:0]  front [ROWS];

    always_ff @(posedge clk) begin
        if (!reset) begin
            {h_s, v_s, r_s, g_s, h_p, v_p} <= '0;
        end else begin
            h_s <= vga_h_sync;
            v_s <= vga_v_sync;
            r_s <= vga_R;
            g_s <= vga_G;
            h_p <= h_s;
            v_p <= v_s;
        end
    end

    // x_eff/y_eff are the coordinates of the staged sample in this cycle, sync-corrected
    always_comb begin
        h_edge  = h_p & ~h_s;
        v_edge  = v_p & ~v_s;
        x_eff   = h_edge ? H_SYNC_X : x;
        y_eff   = v_edge ? V_SYNC_Y : y;
        x_next  = (x_eff == H_LAST) ? '0 : x_eff + CW'(1);
        y_next  = y_eff;
        if (x_eff == H_LAST) begin
            y_next = (y_eff == V_LAST) ? '0 : y_eff + CW'(1);
        end
        col     = x_eff >> TILE_SHIFT;
        row     = y_eff >> TILE_SHIFT;
        col_idx = col[COL_W-1:0];
        row_idx = row[ROW_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            x <= '0;
            y <= '0;
        end else begin
            x <= x_next;
            y <= y_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= SEARCH;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            SEARCH:  if (h_edge)   state_next = HSYNC;
            HSYNC:   if (v_edge)   state_next = LOCKED;
            LOCKED:  if (misalign) state_next = HSYNC;
            default:               state_next = SEARCH;
        endcase
    end

    // misalignment is judged on the free-running X, before the sync reload
    always_comb begin
        locked   = (state == LOCKED);
        misalign = locked & h_edge & (x != H_SYNC_X);
        sample   = locked & ((x_eff & TILE_MASK) == CENTRE) & ((y_eff & TILE_MASK) == CENTRE)
                 & (col < COLS_C) & (row < ROWS_C);
        swap     = locked & v_edge & frame_done & ~misalign;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            frame_done  <= 1'b0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            rd_data     <= '0;
            for (int unsigned r = 0; r < ROWS; r++) begin
                back[r]  <= '0;
                front[r] <= '0;
            end
        end else begin
            // a frame is publishable only once its whole active region was seen while locked
            if (!locked || swap)              frame_done <= 1'b0;
            else if (y_eff == ACTIVE_END_Y)   frame_done <= 1'b1;
            if (sample) back[row_idx][col_idx] <= g_s;
            if (swap) begin
                for (int unsigned r = 0; r < ROWS; r++) front[r] <= back[r];
            end
            frame_valid <= swap;
            sync_err    <= misalign;
            rd_data     <= (32'(rd_row) < ROWS) ? front[rd_row[ROW_W-1:0]] : '0;
        end
    end

`ifdef VGA_BORDER_CHECK_EN
    logic [CW-1:0] bx, by;
    logic          border_red, border_check;

    always_comb begin
        bx           = x_eff >> 3;
        by           = y_eff >> 3;
        border_red   = (bx == '0) | (bx == CW'(79)) | (by == '0) | (by == CW'(59));
        border_check = locked & (x_eff < CW'(640)) & (y_eff < CW'(480));
    end

    always_ff @(posedge clk) begin
        if (!reset)                                   border_err <= 1'b0;
        else if (border_check && (r_s != border_red)) border_err <= 1'b1;
    end
`else
    logic unused_red;
    assign unused_red = r_s;
    assign border_err = 1'b0;
`endif

endmodule

// File: tb/tb_vga_grid_capture.sv
// Self-checking bench for vga_grid_capture on a scaled-down timing (4x4 tiles, 72x60 frame).
module tb_vga_grid_capture;
    localparam int HT = 72, HS = 64, VT = 60, VS = 57, TS = 2, NC = 16, NR = 14;

    logic          clk = 1'b0;
    logic          reset, vga_h_sync, vga_v_sync, vga_R, vga_G;
    logic [3:0]    rd_row;
    logic [NC-1:0] rd_data;
    logic          locked, frame_valid, sync_err, border_err;

    always #5 clk = ~clk;

    vga_grid_capture #(
        .H_TOTAL(HT), .H_SYNC_START(HS), .V_TOTAL(VT), .V_SYNC_LINE(VS),
        .TILE_SHIFT(TS), .COLS(NC), .ROWS(NR)
    ) dut (
        .clk(clk), .reset(reset), .vga_h_sync(vga_h_sync), .vga_v_sync(vga_v_sync),
        .vga_R(vga_R), .vga_G(vga_G), .rd_row(rd_row), .rd_data(rd_data),
        .locked(locked), .frame_valid(frame_valid), .sync_err(sync_err), .border_err(border_err)
    );

    typedef struct packed {
        logic [3:0]  row;
        logic [15:0] exp;
    } rd_vec_t;

    rd_vec_t rq[$];
    int      n_checks = 0, n_fail = 0;
    bit      map [NR][NC];
    int      gx, gy, fv_cnt, se_cnt;
    int      shift_line = -1;
    bit      red_hole = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_pixel();
        int hs, tx, ty;
        hs = (gy == shift_line) ? HS + 5 : HS;
        tx = gx >> TS;
        ty = gy >> TS;
        vga_h_sync = !(gx == hs || gx == hs + 1);
        vga_v_sync = !(gy == VS || gy == VS + 1);
        vga_G = (tx < NC && ty < NR) ? map[ty][tx] : 1'b0;
        vga_R = (((gx >> 3) == 0) || ((gx >> 3) == 79) || ((gy >> 3) == 0) || ((gy >> 3) == 59))
              && !(red_hole && gx == 0 && gy == 20);
        gx++;
        if (gx == HT) begin
            gx = 0;
            gy = (gy + 1) % VT;
        end
    endtask

    task automatic cyc();
        rd_vec_t v;
        @(posedge clk);
        #1;
        fv_cnt += int'(frame_valid);
        se_cnt += int'(sync_err);
        if (rq.size() > 0) begin
            v = rq.pop_front();
            check($sformatf("rd_data[row %0d]", v.row), 32'(rd_data), 32'(v.exp));
        end
        drive_pixel();
    endtask

    task automatic rd(input logic [3:0] row, input logic [15:0] exp);
        rd_row = row;
        rq.push_back('{row: row, exp: exp});
    endtask

    task automatic run_to(input int line);
        int guard;
        guard = 0;
        while (!(gx == 0 && gy == line) && guard < HT * VT + 2) begin
            cyc();
            guard++;
        end
    endtask

    task automatic run_frame();
        cyc();
        run_to(0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " rd_data"}, 32'(rd_data), 32'h0);
        check({tag, " locked"}, 32'(locked), 32'h0);
        check({tag, " frame_valid"}, 32'(frame_valid), 32'h0);
        check({tag, " sync_err"}, 32'(sync_err), 32'h0);
        check({tag, " border_err"}, 32'(border_err), 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rd_vec_t tbl [16];
        for (int i = 0; i < 16; i++) begin
            tbl[i].row = 4'(i);
            tbl[i].exp = 16'h0000;
        end
        tbl[3].exp  = 16'h0004;
        tbl[13].exp = 16'h8000;

        reset = 1'b0; vga_h_sync = 1'b1; vga_v_sync = 1'b1; vga_R = 1'b0; vga_G = 1'b0;
        rd_row = 4'd0; gx = 0; gy = 0; fv_cnt = 0; se_cnt = 0;
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++) map[r][c] = 1'b0;
        map[3][2]   = 1'b1;
        map[13][15] = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b1;

        // frames 1..3: lock on the first vsync, publish from frame 2
        run_to(30);
        check("locked before vsync", 32'(locked), 32'h0);
        run_to(0);
        check("locked after vsync", 32'(locked), 32'h1);
        check("frame_valid count frame 1", 32'(fv_cnt), 32'h0);
        fv_cnt = 0;
        run_frame();
        check("frame_valid count frame 2", 32'(fv_cnt), 32'h1);
        fv_cnt = 0;
        run_frame();
        check("frame_valid count frame 3", 32'(fv_cnt), 32'h1);

        // row table, stepped every cycle; previous row's data must still be showing
        for (int i = 0; i < 16; i++) begin
            rd(tbl[i].row, tbl[i].exp);
            if (i > 0) begin
                #1;
                check("rd_data one-cycle lag", 32'(rd_data), 32'(tbl[i-1].exp));
            end
            cyc();
        end
        run_to(0);

        // misaligned hsync on line 10
        fv_cnt = 0; se_cnt = 0; shift_line = 10;
        run_to(30);
        shift_line = -1;
        check("sync_err pulses mid-frame", 32'(se_cnt), 32'h1);
        check("locked after misalign", 32'(locked), 32'h0);
        run_to(0);
        check("relocked at vsync", 32'(locked), 32'h1);
        check("no publish after misalign", 32'(fv_cnt), 32'h0);
        check("sync_err pulses frame", 32'(se_cnt), 32'h1);
        rd(4'd3, 16'h0004); cyc();
        rd(4'd13, 16'h8000); cyc();

        // swap-cycle read with tile (2,3) cleared in this frame
        map[3][2] = 1'b0;
        rd_row = 4'd3;
        run_to(50);
        fv_cnt = 0;
        for (int k = 0; k < 2000 && frame_valid !== 1'b1; k++) cyc();
        check("frame_valid at swap", 32'(frame_valid), 32'h1);
        check("swap-cycle read old", 32'(rd_data), 32'h0004);
        rd(4'd3, 16'h0000); cyc();
        rd(4'd13, 16'h8000); cyc();
        run_to(0);
        check("frame_valid count toggle frame", 32'(fv_cnt), 32'h1);

        // reset mid-frame
        rd_row = 4'd13;
        run_to(40);
        reset = 1'b0;
        cyc();
        check_all_zero("mid-frame reset");
        reset = 1'b1;
        fv_cnt = 0;
        rd(4'd13, 16'h0000); cyc();
        run_to(0);
        check("no publish in relock frame", 32'(fv_cnt), 32'h0);
        check("locked after relock", 32'(locked), 32'h1);
        run_frame();
        check("publish after full frame", 32'(fv_cnt), 32'h1);
        rd(4'd13, 16'h8000); cyc();
        rd(4'd3, 16'h0000); cyc();

`ifdef VGA_BORDER_CHECK_EN
        check("border_err clean border", 32'(border_err), 32'h0);
        red_hole = 1'b1;
        run_to(30);
        red_hole = 1'b0;
        check("border_err set", 32'(border_err), 32'h1);
        run_to(0);
        check("border_err sticky", 32'(border_err), 32'h1);
        reset = 1'b0;
        cyc();
        check("border_err cleared by reset", 32'(border_err), 32'h0);
        reset = 1'b1;
`else
        check("border_err tied low", 32'(border_err), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
